// File: rtl/button_events_pkg.sv
// rtl/button_events_pkg.sv - state encodings and timing helpers for the button event decoder
package button_events_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PRESS1 = 3'd1,
      ST_LONG   = 3'd2,
      ST_GAP    = 3'd3,
      ST_PRESS2 = 3'd4
   } state_e;

   function automatic int unsigned ms_to_cyc(input int unsigned clock_hz, input int unsigned ms);
      return (clock_hz / 1000) * ms;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_events_if.sv
// rtl/button_events_if.sv - button level in, event pulses out
interface button_events_if;

   logic i_btn;
   logic o_press;
   logic o_release;
   logic o_short;
   logic o_long;
   logic o_double;
   logic o_held;

   modport master (
      output i_btn,
      input  o_press, o_release, o_short, o_long, o_double, o_held
   );

   modport slave (
      input  i_btn,
      output o_press, o_release, o_short, o_long, o_double, o_held
   );

endinterface

// File: rtl/button_events.sv
// rtl/button_events.sv - turns a debounced button level into press/release/short/long/double pulses
module button_events
   import button_events_pkg::*;
#(
   parameter int unsigned CLOCK_HZ = 16_000_000,
   parameter int unsigned LONG_MS  = 1000,
   parameter int unsigned GAP_MS   = 250
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   button_events_if.slave   bus
);

   localparam int unsigned LONG_CYC = ms_to_cyc(CLOCK_HZ, LONG_MS);
   localparam int unsigned GAP_CYC  = ms_to_cyc(CLOCK_HZ, GAP_MS);
   localparam int          CNT_W    = $clog2(max_u(LONG_CYC, GAP_CYC) + 1);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             prev_q, prev_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             short_q, short_d;
   logic             long_q, long_d;
   logic             double_q, double_d;
   logic             held_q, held_d;

   logic             rise;
   logic             fall;

   assign rise = bus.i_btn & ~prev_q;
   assign fall = ~bus.i_btn & prev_q;

   // Edges are checked before counter expiry so that a coincident edge wins.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      prev_d    = bus.i_btn;
      press_d   = 1'b0;
      release_d = 1'b0;
      short_d   = 1'b0;
      long_d    = 1'b0;
      double_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               press_d = 1'b1;
               cnt_d   = '0;
               state_d = ST_PRESS1;
            end
         end
         ST_PRESS1: begin
            if (fall) begin
               release_d = 1'b1;
               cnt_d     = '0;
               state_d   = ST_GAP;
            end else if (cnt_q == LONG_LAST) begin
               long_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_LONG;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_LONG: begin
            if (fall) begin
               release_d = 1'b1;
               cnt_d     = '0;
               state_d   = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (rise) begin
               press_d = 1'b1;
               cnt_d   = '0;
               state_d = ST_PRESS2;
            end else if (cnt_q == GAP_LAST) begin
               short_d = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_PRESS2: begin
            if (fall) begin
               release_d = 1'b1;
               double_d  = 1'b1;
               cnt_d     = '0;
               state_d   = ST_IDLE;
            end else if (cnt_q == LONG_LAST) begin
               long_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_LONG;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase

      held_d = (state_d == ST_PRESS1) || (state_d == ST_LONG) || (state_d == ST_PRESS2);
   end

   // prev resets high so a button held through reset is not taken as a press.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         prev_q    <= 1'b1;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         short_q   <= 1'b0;
         long_q    <= 1'b0;
         double_q  <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         prev_q    <= prev_d;
         press_q   <= press_d;
         release_q <= release_d;
         short_q   <= short_d;
         long_q    <= long_d;
         double_q  <= double_d;
         held_q    <= held_d;
      end
   end

   assign bus.o_press   = press_q;
   assign bus.o_release = release_q;
   assign bus.o_short   = short_q;
   assign bus.o_long    = long_q;
   assign bus.o_double  = double_q;
   assign bus.o_held    = held_q;

endmodule

// File: tb/tb_button_events.sv
// tb/tb_button_events.sv - directed gesture table and reset corner cases for button_events
module tb_button_events;

   typedef struct {
      logic  btn;
      int    ncyc;
      int    p_at;
      int    r_at;
      int    s_at;
      int    l_at;
      int    d_at;
      logic  held_end;
      string name;
   } seg_t;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   button_events_if bus ();

   button_events #(
      .CLOCK_HZ (1000),
      .LONG_MS  (20),
      .GAP_MS   (10)
   ) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic seg_t mk(input logic btn, input int ncyc, input int p_at, input int r_at,
                               input int s_at, input int l_at, input int d_at,
                               input logic held_end, input string name);
      seg_t s;
      s.btn = btn; s.ncyc = ncyc; s.p_at = p_at; s.r_at = r_at; s.s_at = s_at;
      s.l_at = l_at; s.d_at = d_at; s.held_end = held_end; s.name = name;
      return s;
   endfunction

   // -1 = never fired, -2 = fired more than once, otherwise the cycle index it fired on
   function automatic int upd(input int cur, input logic v, input int i);
      if (!v) return cur;
      return (cur == -1) ? i : -2;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Index i is the i-th rising edge after the level is applied; outputs are sampled 1 time unit after it.
   task automatic run_seg(input seg_t s);
      int p, r, sh, l, d;
      logic held;
      p = -1; r = -1; sh = -1; l = -1; d = -1; held = 1'b0;
      for (int i = 0; i < s.ncyc; i++) begin
         bus.i_btn = s.btn;
         @(posedge clk);
         #1;
         p  = upd(p,  bus.o_press,   i);
         r  = upd(r,  bus.o_release, i);
         sh = upd(sh, bus.o_short,   i);
         l  = upd(l,  bus.o_long,    i);
         d  = upd(d,  bus.o_double,  i);
         held = bus.o_held;
      end
      chk({s.name, ".press"},   p,  s.p_at);
      chk({s.name, ".release"}, r,  s.r_at);
      chk({s.name, ".short"},   sh, s.s_at);
      chk({s.name, ".long"},    l,  s.l_at);
      chk({s.name, ".double"},  d,  s.d_at);
      chk({s.name, ".held"},    int'(held), int'(s.held_end));
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, ".press"},   int'(bus.o_press),   0);
      chk({name, ".release"}, int'(bus.o_release), 0);
      chk({name, ".short"},   int'(bus.o_short),   0);
      chk({name, ".long"},    int'(bus.o_long),    0);
      chk({name, ".double"},  int'(bus.o_double),  0);
      chk({name, ".held"},    int'(bus.o_held),    0);
   endtask

   seg_t tbl[$];

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      bus.i_btn = 1'b0;
      rst_n     = 1'b0;

      // LONG_CYC = 20, GAP_CYC = 10
      tbl.push_back(mk(1'b1,  5,  0, -1, -1, -1, -1, 1'b1, "short_dn"));
      tbl.push_back(mk(1'b0, 15, -1,  0, 10, -1, -1, 1'b0, "short_up"));
      tbl.push_back(mk(1'b1, 30,  0, -1, -1, 20, -1, 1'b1, "long_dn"));
      tbl.push_back(mk(1'b0, 15, -1,  0, -1, -1, -1, 1'b0, "long_up"));
      tbl.push_back(mk(1'b1,  3,  0, -1, -1, -1, -1, 1'b1, "dbl_dn1"));
      tbl.push_back(mk(1'b0,  4, -1,  0, -1, -1, -1, 1'b0, "dbl_up1"));
      tbl.push_back(mk(1'b1,  3,  0, -1, -1, -1, -1, 1'b1, "dbl_dn2"));
      tbl.push_back(mk(1'b0, 15, -1,  0, -1, -1,  0, 1'b0, "dbl_up2"));
      tbl.push_back(mk(1'b1,  3,  0, -1, -1, -1, -1, 1'b1, "gapedge_dn1"));
      tbl.push_back(mk(1'b0, 10, -1,  0, -1, -1, -1, 1'b0, "gapedge_up1"));
      tbl.push_back(mk(1'b1,  3,  0, -1, -1, -1, -1, 1'b1, "gapedge_dn2"));
      tbl.push_back(mk(1'b0, 15, -1,  0, -1, -1,  0, 1'b0, "gapedge_up2"));
      tbl.push_back(mk(1'b1,  3,  0, -1, -1, -1, -1, 1'b1, "gaplate_dn1"));
      tbl.push_back(mk(1'b0, 11, -1,  0, 10, -1, -1, 1'b0, "gaplate_up1"));
      tbl.push_back(mk(1'b1,  3,  0, -1, -1, -1, -1, 1'b1, "gaplate_dn2"));
      tbl.push_back(mk(1'b0, 15, -1,  0, 10, -1, -1, 1'b0, "gaplate_up2"));
      tbl.push_back(mk(1'b1, 20,  0, -1, -1, -1, -1, 1'b1, "longedge_dn"));
      tbl.push_back(mk(1'b0, 15, -1,  0, 10, -1, -1, 1'b0, "longedge_up"));
      tbl.push_back(mk(1'b1, 21,  0, -1, -1, 20, -1, 1'b1, "longjust_dn"));
      tbl.push_back(mk(1'b0, 15, -1,  0, -1, -1, -1, 1'b0, "longjust_up"));
      tbl.push_back(mk(1'b1,  3,  0, -1, -1, -1, -1, 1'b1, "p2long_dn1"));
      tbl.push_back(mk(1'b0,  4, -1,  0, -1, -1, -1, 1'b0, "p2long_up1"));
      tbl.push_back(mk(1'b1, 25,  0, -1, -1, 20, -1, 1'b1, "p2long_dn2"));
      tbl.push_back(mk(1'b0, 15, -1,  0, -1, -1, -1, 1'b0, "p2long_up2"));

      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
      run_seg(mk(1'b0, 5, -1, -1, -1, -1, -1, 1'b0, "post_reset_idle"));

      foreach (tbl[k]) run_seg(tbl[k]);

      // Button held through reset release: first fall is ignored, only the next press counts.
      bus.i_btn = 1'b1;
      rst_n     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_seg(mk(1'b1,  5, -1, -1, -1, -1, -1, 1'b0, "thru_hold"));
      run_seg(mk(1'b0,  5, -1, -1, -1, -1, -1, 1'b0, "thru_rel"));
      run_seg(mk(1'b1,  3,  0, -1, -1, -1, -1, 1'b1, "thru_dn"));
      run_seg(mk(1'b0, 15, -1,  0, 10, -1, -1, 1'b0, "thru_up"));

      // Reset mid-press clears outputs asynchronously and leaves nothing pending.
      run_seg(mk(1'b1, 5, 0, -1, -1, -1, -1, 1'b1, "midrst_dn"));
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst_async");
      repeat (3) @(posedge clk);
      #1;
      bus.i_btn = 1'b0;
      rst_n     = 1'b1;
      run_seg(mk(1'b0, 30, -1, -1, -1, -1, -1, 1'b0, "midrst_after"));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
